// File: rtl/programmable_tick_divider_pkg.sv
// programmable_tick_divider_pkg: divider widths and default divisors shared with the display controller
package programmable_tick_divider_pkg;
  localparam int WIDTH = 16;
  localparam int DEFAULT_REFRESH_DIVISOR = 50000;
  localparam int DEFAULT_BLINK_DIVISOR = 25000;
endpackage

// File: rtl/divider_channel.sv
// divider_channel: one divider with a shadow divisor swapped in at wrap or restart
module divider_channel #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] DEFAULT_DIVISOR = 50000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             restart_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_divisor_i,
  output logic             pending_o,
  output logic             tick_o,
  output logic             square_o
);
  localparam logic [WIDTH-1:0] ONE = 1;
  logic [WIDTH-1:0] count_q, count_d, div_q, div_d, shadow_q, shadow_d, ne, ne_next;
  logic pending_q, pending_d, tick_q, tick_d, square_q, square_d, wrap, apply;
  assign ne = (div_q == '0) ? ONE : div_q;
  assign wrap = count_q == ne - ONE;
  assign apply = pending_q & (restart_i | (enable_i & wrap));
  assign div_d = apply ? shadow_q : div_q;
  assign ne_next = (div_d == '0) ? ONE : div_d;
  assign count_d = restart_i ? '0 : !enable_i ? count_q : wrap ? '0 : count_q + ONE;
  assign tick_d = ~restart_i & enable_i & wrap;
  // Square compares the post-edge count against the divisor that governs the next period
  assign square_d = (restart_i | enable_i) ? (count_d < (ne_next >> 1)) : square_q;
  assign pending_d = load_i | (pending_q & ~apply);
  assign shadow_d = load_i ? load_divisor_i : shadow_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q   <= '0;
      div_q     <= DEFAULT_DIVISOR;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      square_q  <= 1'b0;
    end else begin
      count_q   <= count_d;
      div_q     <= div_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
      square_q  <= square_d;
    end
  end
  assign pending_o = pending_q;
  assign tick_o = tick_q;
  assign square_o = square_q;
endmodule

// File: rtl/programmable_tick_divider.sv
// programmable_tick_divider: multi-channel tick/square divider with a valid/ready divisor load port
module programmable_tick_divider
  import programmable_tick_divider_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH = programmable_tick_divider_pkg::WIDTH,
  parameter int DEFAULT_DIVISOR = DEFAULT_REFRESH_DIVISOR,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                restart,
  input  logic                loadValid,
  input  logic [CW-1:0]       loadChannel,
  input  logic [WIDTH-1:0]    loadDivisor,
  output logic                loadReady,
  output logic [CHANNELS-1:0] ticks,
  output logic [CHANNELS-1:0] squares
);
  localparam logic [WIDTH-1:0] DEF = DEFAULT_DIVISOR[WIDTH-1:0];
  logic reset_q;
  logic [CHANNELS-1:0] pending;
  logic in_range, accept;
  always_ff @(posedge clock) reset_q <= reset;
  // Out-of-range channels always accept so the handshake completes and the data is dropped
  assign in_range = 32'(loadChannel) < CHANNELS;
  assign loadReady = ~reset_q & ~(in_range & pending[loadChannel]);
  assign accept = loadValid & loadReady;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    divider_channel #(.WIDTH(WIDTH), .DEFAULT_DIVISOR(DEF)) u_ch (
      .clock(clock),
      .reset(reset),
      .enable_i(enable),
      .restart_i(restart),
      .load_i(accept & (32'(loadChannel) == i)),
      .load_divisor_i(loadDivisor),
      .pending_o(pending[i]),
      .tick_o(ticks[i]),
      .square_o(squares[i])
    );
  end
endmodule
